// File: rtl/dense_layer_pkg.sv
// dense_layer_pkg
// Shared definitions for the sequential dense-layer controller:
//   - DEFAULT_IN_DIM / DEFAULT_OUT_DIM : default vector length and neuron count
//   - state_t                          : controller state encoding
package dense_layer_pkg;

    localparam int DEFAULT_IN_DIM  = 16;
    localparam int DEFAULT_OUT_DIM = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DRAIN,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/dense_layer_seq.sv
// dense_layer_seq
// Sequences an external MAC through one dense layer: for every output neuron it
// clears the accumulator, streams IN_DIM operand pairs from the x/w memories,
// waits out the read latency and writes the accumulated result.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   start             : run launch on rising edge (IDLE/DONE only)
//   debug_rst_local   : synchronous abort back to IDLE
//   rd_en             : operand read strobe (1-cycle memory latency)
//   x_addr, w_addr    : input-vector and weight indices
//   mac_clr, mac_en   : accumulator clear / accumulate enables
//   acc_in            : accumulator value from the MAC
//   y_we, y_addr      : result write strobe and neuron index
//   output_y0         : captured result of neuron 0
//   debug_counter     : RUN-cycle count of current/last run (saturating)
//   start_time        : cycle-counter snapshot at launch
//   end_time          : cycle-counter value in the cycle all_done rises
//   all_done          : run complete, held until next launch or abort
module dense_layer_seq
    import dense_layer_pkg::*;
#(
    parameter int IN_DIM  = DEFAULT_IN_DIM,
    parameter int OUT_DIM = DEFAULT_OUT_DIM,
    localparam int XW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1,
    localparam int WW = (IN_DIM * OUT_DIM > 1) ? $clog2(IN_DIM * OUT_DIM) : 1,
    localparam int YW = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 debug_rst_local,
    output logic                 rd_en,
    output logic [XW-1:0]        x_addr,
    output logic [WW-1:0]        w_addr,
    output logic                 mac_clr,
    output logic                 mac_en,
    input  logic signed [31:0]   acc_in,
    output logic                 y_we,
    output logic [YW-1:0]        y_addr,
    output logic signed [31:0]   output_y0,
    output logic [31:0]          debug_counter,
    output logic [63:0]          start_time,
    output logic [63:0]          end_time,
    output logic                 all_done
);

    state_t         state;
    state_t         state_next;
    logic           start_q;
    logic [XW-1:0]  i_idx;
    logic [YW-1:0]  o_idx;
    logic [63:0]    cycle_cnt;
    logic           launch;
    logic           last_in;
    logic           last_out;

    // A launch needs a fresh rising edge of start and a controller at rest;
    // edges seen mid-run are simply dropped.
    assign launch   = start && !start_q && (state == ST_IDLE || state == ST_DONE);
    assign last_in  = (i_idx == XW'(IN_DIM - 1));
    assign last_out = (o_idx == YW'(OUT_DIM - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; the abort overrides every transition including launch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (launch) state_next = ST_CLEAR;
            ST_CLEAR: state_next = ST_RUN;
            ST_RUN:   if (last_in) state_next = ST_DRAIN;
            ST_DRAIN: state_next = ST_WRITE;
            ST_WRITE: state_next = last_out ? ST_DONE : ST_CLEAR;
            ST_DONE:  if (launch) state_next = ST_CLEAR;
            default:  state_next = ST_IDLE;
        endcase
        if (debug_rst_local) begin
            state_next = ST_IDLE;
        end
    end

    // Strobes and addresses are pure decodes of the state and indices.
    always_comb begin
        rd_en   = (state == ST_RUN);
        mac_clr = (state == ST_CLEAR);
        y_we    = (state == ST_WRITE);
        x_addr  = i_idx;
        w_addr  = WW'(o_idx) * WW'(IN_DIM) + WW'(i_idx);
        y_addr  = o_idx;
    end

    // Datapath: indices, counters, timestamps and captured results.
    // end_time takes cycle_cnt+1 so it holds the counter value of the cycle in
    // which all_done is first visible, matching how start_time is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            start_q       <= 1'b0;
            cycle_cnt     <= '0;
            mac_en        <= 1'b0;
            i_idx         <= '0;
            o_idx         <= '0;
            all_done      <= 1'b0;
            debug_counter <= '0;
            start_time    <= '0;
            end_time      <= '0;
            output_y0     <= '0;
        end else begin
            start_q   <= start;
            cycle_cnt <= cycle_cnt + 64'd1;
            mac_en    <= rd_en;
            if (debug_rst_local) begin
                mac_en        <= 1'b0;
                i_idx         <= '0;
                o_idx         <= '0;
                all_done      <= 1'b0;
                debug_counter <= '0;
            end else begin
                if (launch) begin
                    o_idx         <= '0;
                    all_done      <= 1'b0;
                    debug_counter <= '0;
                    start_time    <= cycle_cnt;
                end
                case (state)
                    ST_CLEAR: i_idx <= '0;
                    ST_RUN: begin
                        if (!last_in) begin
                            i_idx <= i_idx + XW'(1);
                        end
                        if (debug_counter != 32'hFFFF_FFFF) begin
                            debug_counter <= debug_counter + 32'd1;
                        end
                    end
                    ST_WRITE: begin
                        if (o_idx == '0) begin
                            output_y0 <= acc_in;
                        end
                        if (last_out) begin
                            all_done <= 1'b1;
                            end_time <= cycle_cnt + 64'd1;
                        end else begin
                            o_idx <= o_idx + YW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dense_layer_seq.sv
// tb_dense_layer_seq
// Randomized bench for dense_layer_seq. The bench supplies x/w memories with
// one-cycle read latency and a MAC around the DUT, then compares the written
// results against dot products computed directly from the memory contents,
// along with the run timing, strobe counts and abort/reset behaviour.
module tb_dense_layer_seq;

    localparam int IN  = 16;
    localparam int OUT = 4;
    localparam int LAT = OUT * (IN + 3) + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        debug_rst_local;
    logic        rd_en;
    logic [3:0]  x_addr;
    logic [5:0]  w_addr;
    logic        mac_clr;
    logic        mac_en;
    logic [31:0] acc_in;
    logic        y_we;
    logic [1:0]  y_addr;
    logic [31:0] output_y0;
    logic [31:0] debug_counter;
    logic [63:0] start_time;
    logic [63:0] end_time;
    logic        all_done;

    dense_layer_seq #(.IN_DIM(IN), .OUT_DIM(OUT)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .debug_rst_local(debug_rst_local),
        .rd_en(rd_en),
        .x_addr(x_addr),
        .w_addr(w_addr),
        .mac_clr(mac_clr),
        .mac_en(mac_en),
        .acc_in(acc_in),
        .y_we(y_we),
        .y_addr(y_addr),
        .output_y0(output_y0),
        .debug_counter(debug_counter),
        .start_time(start_time),
        .end_time(end_time),
        .all_done(all_done)
    );

    always #5 clk = ~clk;

    // Environment: operand memories, MAC and a reference cycle counter.
    int          x_mem [IN];
    int          w_mem [IN*OUT];
    int          x_q = 0;
    int          w_q = 0;
    logic [31:0] acc = '0;
    logic [63:0] tb_cycle = '0;

    assign acc_in = acc;

    always @(posedge clk) begin
        if (rd_en) begin
            x_q <= x_mem[x_addr];
            w_q <= w_mem[w_addr];
        end
        if (mac_clr) acc <= '0;
        else if (mac_en) acc <= acc + 32'(x_q * w_q);
        tb_cycle <= rst ? 64'd0 : tb_cycle + 64'd1;
    end

    // Event monitor: running totals of strobes plus a log of every write.
    int          n_clr_tot = 0;
    int          n_rd_tot  = 0;
    int          n_we_tot  = 0;
    int          bad_excl  = 0;
    int          we_addr_q [$];
    logic [31:0] we_val_q  [$];

    always @(negedge clk) begin
        if (mac_clr) n_clr_tot++;
        if (rd_en) n_rd_tot++;
        if (mac_clr && y_we) bad_excl++;
        if (y_we) begin
            n_we_tot++;
            we_addr_q.push_back(int'(y_addr));
            we_val_q.push_back(acc_in);
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] last_exp_start = '0;
    logic [63:0] last_exp_end   = '0;
    logic [31:0] exp_y [OUT];

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic d);
        @(negedge clk);
        start           = s;
        debug_rst_local = d;
    endtask

    // Fresh random operands, then the expected result of every neuron.
    task automatic randomize_mem();
        for (int i = 0; i < IN; i++) x_mem[i] = int'($urandom_range(0, 255)) - 128;
        for (int k = 0; k < IN*OUT; k++) w_mem[k] = int'($urandom_range(0, 255)) - 128;
    endtask

    task automatic compute_expected();
        int s;
        for (int o = 0; o < OUT; o++) begin
            s = 0;
            for (int i = 0; i < IN; i++) s += x_mem[i] * w_mem[o*IN + i];
            exp_y[o] = 32'(s);
        end
    endtask

    // Launch one full run and check timing, strobe counts and results.
    task automatic run_layer(input int pulse_at, input string name);
        int n;
        int clr0, rd0, we0;
        compute_expected();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        clr0 = n_clr_tot;
        rd0  = n_rd_tot;
        we0  = n_we_tot;
        last_exp_start = tb_cycle;
        n = 0;
        while (n == 0 || (n < LAT + 20 && all_done !== 1'b1)) begin
            @(negedge clk);
            n++;
            if (n == 1) checkOutput({name, "_done_low_after_launch"}, 64'(all_done), 64'd0);
            if (pulse_at > 0 && n == pulse_at) start = 1'b0;
            if (pulse_at > 0 && n == pulse_at + 2) start = 1'b1;
        end
        last_exp_end = last_exp_start + 64'(LAT);
        checkOutput({name, "_done_latency"}, 64'(n), 64'(LAT));
        checkOutput({name, "_start_time"}, start_time, last_exp_start);
        checkOutput({name, "_elapsed"}, end_time - start_time, 64'(LAT));
        checkOutput({name, "_debug_counter"}, 64'(debug_counter), 64'(IN*OUT));
        checkOutput({name, "_clear_pulses"}, 64'(n_clr_tot - clr0), 64'(OUT));
        checkOutput({name, "_reads"}, 64'(n_rd_tot - rd0), 64'(IN*OUT));
        checkOutput({name, "_writes"}, 64'(n_we_tot - we0), 64'(OUT));
        for (int k = 0; k < OUT; k++) begin
            if (we0 + k < we_addr_q.size()) begin
                checkOutput($sformatf("%s_y_addr%0d", name, k), 64'(we_addr_q[we0+k]), 64'(k));
                checkOutput($sformatf("%s_y%0d", name, k), 64'(we_val_q[we0+k]), 64'(exp_y[k]));
            end else begin
                checkOutput($sformatf("%s_missing_write%0d", name, k), 64'(we_addr_q.size()), 64'(we0 + k + 1));
            end
        end
        checkOutput({name, "_output_y0"}, 64'(output_y0), 64'(exp_y[0]));
    endtask

    initial begin
        int clr0, we0;
        bit found;
        rst             = 1'b1;
        start           = 1'b0;
        debug_rst_local = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_rd_en", 64'(rd_en), 64'd0);
        checkOutput("rst_mac_clr", 64'(mac_clr), 64'd0);
        checkOutput("rst_mac_en", 64'(mac_en), 64'd0);
        checkOutput("rst_y_we", 64'(y_we), 64'd0);
        checkOutput("rst_all_done", 64'(all_done), 64'd0);
        checkOutput("rst_debug_counter", 64'(debug_counter), 64'd0);
        checkOutput("rst_start_time", start_time, 64'd0);
        checkOutput("rst_end_time", end_time, 64'd0);
        checkOutput("rst_output_y0", 64'(output_y0), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Plain random run.
        randomize_mem();
        run_layer(0, "run1");

        // Start held high after DONE must not relaunch.
        clr0 = n_clr_tot;
        repeat (30) applyStimulus(1'b1, 1'b0);
        checkOutput("held_no_relaunch", 64'(n_clr_tot - clr0), 64'd0);
        checkOutput("held_all_done", 64'(all_done), 64'd1);

        // Second run with a start re-pulse in the middle of RUN.
        randomize_mem();
        run_layer(10, "run2");

        // Neuron 0 engineered to produce -5.
        randomize_mem();
        x_mem[0] = 1;
        for (int i = 0; i < IN; i++) w_mem[i] = 0;
        w_mem[0] = -5;
        run_layer(0, "run3");
        checkOutput("neg5_output_y0", 64'(output_y0), 64'(32'hFFFF_FFFB));

        // Abort during RUN of neuron 2.
        randomize_mem();
        compute_expected();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        clr0 = n_clr_tot;
        we0  = n_we_tot;
        last_exp_start = tb_cycle;
        for (int n = 0; n < 1 + 2*(IN+3) + 1 + 5; n++) @(negedge clk);
        checkOutput("abort_in_run", 64'(rd_en), 64'd1);
        debug_rst_local = 1'b1;
        @(negedge clk);
        debug_rst_local = 1'b0;
        checkOutput("abort_rd_en", 64'(rd_en), 64'd0);
        checkOutput("abort_mac_en", 64'(mac_en), 64'd0);
        checkOutput("abort_mac_clr", 64'(mac_clr), 64'd0);
        checkOutput("abort_all_done", 64'(all_done), 64'd0);
        checkOutput("abort_debug_counter", 64'(debug_counter), 64'd0);
        checkOutput("abort_start_time", start_time, last_exp_start);
        checkOutput("abort_end_time_kept", end_time, last_exp_end);
        checkOutput("abort_output_y0", 64'(output_y0), 64'(exp_y[0]));
        repeat (60) @(negedge clk);
        checkOutput("abort_writes", 64'(n_we_tot - we0), 64'd2);
        checkOutput("abort_clears", 64'(n_clr_tot - clr0), 64'd3);

        // Start edge coincident with abort is discarded.
        applyStimulus(1'b0, 1'b0);
        clr0 = n_clr_tot;
        applyStimulus(1'b1, 1'b1);
        repeat (10) applyStimulus(1'b1, 1'b0);
        checkOutput("coincident_no_launch", 64'(n_clr_tot - clr0), 64'd0);
        checkOutput("coincident_all_done", 64'(all_done), 64'd0);

        // Launch from IDLE after the abort.
        randomize_mem();
        run_layer(0, "run4");

        // Reset during WRITE of neuron 1.
        randomize_mem();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 3 * (IN + 3) && !found; n++) begin
            @(negedge clk);
            if (y_we === 1'b1 && y_addr === 2'd1) found = 1'b1;
        end
        checkOutput("rst_write_reached", 64'(found), 64'd1);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        we0  = n_we_tot;
        clr0 = n_clr_tot;
        checkOutput("wrst_y_we", 64'(y_we), 64'd0);
        checkOutput("wrst_rd_en", 64'(rd_en), 64'd0);
        checkOutput("wrst_mac_en", 64'(mac_en), 64'd0);
        checkOutput("wrst_all_done", 64'(all_done), 64'd0);
        checkOutput("wrst_debug_counter", 64'(debug_counter), 64'd0);
        checkOutput("wrst_output_y0", 64'(output_y0), 64'd0);
        checkOutput("wrst_start_time", start_time, 64'd0);
        checkOutput("wrst_end_time", end_time, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        checkOutput("wrst_no_more_writes", 64'(n_we_tot - we0), 64'd0);
        checkOutput("wrst_no_more_clears", 64'(n_clr_tot - clr0), 64'd0);

        checkOutput("clr_we_exclusive", 64'(bad_excl), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/dense_layer_seq.md
DENSE_LAYER_SEQ -- requirements
Module: dense_layer_seq

Interface
REQ-001: Parameter IN_DIM, default 16, input vector length (≥2).
REQ-002: Parameter OUT_DIM, default 4, output neuron count (≥1).
REQ-003: Ports clk and rst SHALL be: one clock, reset is synchronous and active-high.
REQ-004: clk  in  1  sole clock; rst  in  1  synchronous active-high reset.
REQ-005: start  in  1  level from the AXI-Lite start register; run launches on its rising edge.
REQ-006: debug_rst_local  in  1  synchronous abort from the AXI-Lite register.
REQ-007: rd_en  out  1  operand read strobe to the x and w memories (1-cycle read latency).
REQ-008: x_addr  out  clog2(IN_DIM)  input-vector index; w_addr  out  clog2(IN_DIM*OUT_DIM)  weight index.
REQ-009: mac_clr  out  1  clears the MAC accumulator; mac_en  out  1  MAC accumulates current operands.
REQ-010: acc_in  in  32 signed  MAC accumulator value.
REQ-011: y_we  out  1  result write strobe; y_addr  out  clog2(OUT_DIM)  result index.
REQ-012: output_y0  out  32 signed  captured result of neuron 0.
REQ-013: debug_counter  out  32  RUN-state cycle count of the current or last run.
REQ-014: start_time, end_time  out  64 each  free-running cycle-counter snapshots.
REQ-015: all_done  out  1  run complete, held until next launch or abort.

Function
REQ-016: States: IDLE, CLEAR, RUN, DRAIN, WRITE, DONE; state enum from the package.
REQ-017: Launch = start high and registered start_q low, accepted only in IDLE or DONE; next state CLEAR; neuron index o cleared; all_done cleared; debug_counter cleared; start_time <= cycle counter.
REQ-018: Rising start edge in any other state is ignored; start held high never relaunches.
REQ-019: CLEAR: mac_clr=1 for exactly 1 cycle; input index i cleared; next RUN.
REQ-020: RUN: IN_DIM cycles, rd_en=1, x_addr=i, w_addr=o*IN_DIM+i, i increments; after i=IN_DIM-1 go to DRAIN.
REQ-021: mac_en SHALL equal rd_en delayed one cycle (covers memory latency); DRAIN lasts 1 cycle.
REQ-022: WRITE: y_we=1, y_addr=o for 1 cycle; if o=0, output_y0 <= acc_in; then o<OUT_DIM-1 -> o+1, CLEAR; else DONE.
REQ-023: Entering DONE: end_time <= cycle counter (same cycle all_done rises), all_done=1.
REQ-024: Latency: launch-sample cycle = 0; all_done first high at cycle OUT_DIM*(IN_DIM+3)+1.
REQ-025: debug_counter increments once per RUN cycle, saturating at 32'hFFFF_FFFF.
REQ-026: Cycle counter: 64-bit free-running, +1 every cycle, wraps at 2^64-1 to 0.
REQ-027: debug_rst_local high (any state): next state IDLE; all_done, debug_counter, o, i cleared; rd_en/mac_en/mac_clr/y_we low next cycle; start_time, end_time, output_y0, cycle counter untouched.
REQ-028: Priority: rst > debug_rst_local > launch; start edge coincident with debug_rst_local is discarded (start_q still updates).
REQ-029: rd_en, mac_clr, y_we are registered-free state decodes; at most one of mac_clr, y_we high per cycle.

Reset
REQ-030: rst SHALL set state IDLE, start_q 0, o and i 0, rd_en/mac_en/mac_clr/y_we 0, all_done 0.
REQ-031: rst SHALL zero debug_counter, cycle counter, start_time, end_time, output_y0.
REQ-032: rst mid-run SHALL abandon the run with no further y_we.

Structure
REQ-033: dense_layer_pkg SHALL hold the state enum and default IN_DIM/OUT_DIM constants.
REQ-034: Single flat module; no sub-module (edge detector and counters inline).

Verification
REQ-035: rst, start 0->1 (IN=16, OUT=4) -> 4 CLEAR pulses, 64 rd_en, 4 y_we at y_addr 0..3, all_done at cycle 77, end_time-start_time=77, debug_counter=64.
REQ-036: acc_in=-5 during WRITE with o=0 -> output_y0=32'hFFFF_FFFB; other writes leave it unchanged.
REQ-037: start held high after DONE -> no relaunch; drop then raise -> second run, all_done low cycle after edge.
REQ-038: start re-pulsed during RUN -> ignored, run timing identical to REQ-035.
REQ-039: debug_rst_local mid-RUN of neuron 2 -> IDLE next cycle, all_done 0, debug_counter 0, no y_we for neurons 2,3.
REQ-040: rst asserted in WRITE -> y_we low next cycle, all outputs at reset values.
